akash_dmem_resp: RTL

//  Data-memory responder: slave end of the core's load/store port. Accepts one word

---
 rtl/akash_dmem_resp.sv | 88 ++++++++
 1 files changed

// File: rtl/akash_dmem_resp.sv
// akash_dmem_resp: data-memory responder, one word load/store at a time with LATENCY wait states
// Ports:
//   clk, RN                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata  store flag, word address, store data (sampled at accept)
//   rsp_valid/rsp_ready      response handshake (valid only in RESP)
//   rsp_rdata/rsp_err        load data (0 for stores/errors), address-out-of-range flag
//   busy                     state != IDLE
//   rd_count/wr_count        completed loads/stores including errored, wrapping
module akash_dmem_resp #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        RN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_LD = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH];
    logic        acc, acc_we, acc_ok;
    logic [31:0] acc_addr, acc_wdata;
    // With zero wait states the access uses the live request fields in the accept cycle;
    // otherwise it uses the fields captured at accept.
    always_comb begin
        acc_we    = state == IDLE ? req_we : we_q;
        acc_addr  = state == IDLE ? req_addr : addr_q;
        acc_wdata = state == IDLE ? req_wdata : wdata_q;
        acc       = (state == IDLE && req_valid && LATENCY == 0) || (state == WAIT && cnt == 4'd0);
        acc_ok    = acc_addr < 32'(DEPTH);
        state_nx  = state;
        case (state)
            IDLE:    state_nx = req_valid ? (LATENCY == 0 ? RESP : WAIT) : IDLE;
            WAIT:    state_nx = cnt == 4'd0 ? RESP : WAIT;
            default: state_nx = rsp_ready ? IDLE : RESP;
        endcase
    end
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= LAT_LD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (acc) begin
                rsp_err   <= !acc_ok;
                rsp_rdata <= (acc_ok && !acc_we) ? mem[acc_addr[AW-1:0]] : '0;
                if (acc_ok && acc_we) mem[acc_addr[AW-1:0]] <= acc_wdata;
                if (acc_we) wr_count <= wr_count + 16'd1;
                else rd_count <= rd_count + 16'd1;
            end
        end
    end
endmodule
